pe_array_ctrl: RTL and testbench

Sequencer for the 8-bit binary-parallel systolic PE array. It drives the enable/clear control pins (`en_i/clr_i`, `en_w/clr_w`, `en_o/clr_o`) into the border PE; those pins then ripple through the array on each PE's one-cycle control delay. It also issues read strobes to the weight and ifm buffers and flags when ofm results leave the array. It runs one tile per `start`: clear, weight load, ifm stream, drain, done.

---
 rtl/pe_array_ctrl_pkg.sv | 25 ++
 rtl/pe_array_ctrl_if.sv | 33 +++
 rtl/pe_array_ctrl_delay.sv | 19 +
 rtl/pe_array_ctrl.sv | 148 ++++++++++++++
 tb/tb_pe_array_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pe_array_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic PE array sequencer.
// Pure declarations: no latency, no flow control.
package pe_array_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOADW,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // Cycles from a vector entering the border PE to its result leaving the array.
  function automatic int lat(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  function automatic int cnt_width(input int lwidth, input int rows, input int cols);
    int w;
    w = $clog2(rows + cols) + 1;
    return (lwidth > w) ? lwidth : w;
  endfunction

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Host-side bundle of the PE array sequencer: tile requests in, array controls and status out.
// Wires only: no latency; no backpressure, start is simply ignored while busy.
interface pe_array_ctrl_if #(
  parameter int LWIDTH = 16
);
  logic              start;
  logic              abort;
  logic [LWIDTH-1:0] num_vec;
  logic              busy;
  logic              done;
  logic              wght_rd;
  logic              ifm_rd;
  logic              en_w;
  logic              clr_w;
  logic              en_i;
  logic              clr_i;
  logic              en_o;
  logic              clr_o;
  logic              ofm_vld;
  logic [LWIDTH-1:0] ofm_idx;

  modport master (
    output start, abort, num_vec,
    input  busy, done, wght_rd, ifm_rd, en_w, clr_w, en_i, clr_i, en_o, clr_o,
           ofm_vld, ofm_idx
  );

  modport slave (
    input  start, abort, num_vec,
    output busy, done, wght_rd, ifm_rd, en_w, clr_w, en_i, clr_i, en_o, clr_o,
           ofm_vld, ofm_idx
  );
endinterface

// File: rtl/pe_array_ctrl_delay.sv
// ctrl_delay: DEPTH-cycle 1-bit shift register with synchronous clear.
// Latency DEPTH cycles; no backpressure, shifts every cycle.
module ctrl_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (clr) sr <= '0;
    else     sr <= (sr << 1) | DEPTH'(d);
  end

  assign q = sr[DEPTH-1];
endmodule

// File: rtl/pe_array_ctrl.sv
// Tile sequencer for the systolic PE array: clear, weight load, ifm stream, drain, done.
// Outputs are Moore-decoded (registered); no backpressure, start is ignored while busy.
module pe_array_ctrl
  import pe_array_ctrl_pkg::*;
#(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int LWIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  pe_array_ctrl_if.slave ctl
);
  localparam int LAT = lat(ROWS, COLS);
  localparam int CW  = cnt_width(LWIDTH, ROWS, COLS);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [LWIDTH-1:0] nv_q;
  logic [LWIDTH-1:0] idx_q;
  logic              abort_acc;
  logic              ofm_vld;

  assign abort_acc = ctl.abort && (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      nv_q  <= '0;
      idx_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && ctl.start) nv_q <= ctl.num_vec;
      // Cleared in DONE as well so the index reads 0 once back in IDLE.
      if (abort_acc || state == CLR || state == DONE) idx_q <= '0;
      else if (ofm_vld)                               idx_q <= idx_q + LWIDTH'(1);
    end
  end

  // Phase counter counts down to zero and is reloaded on every state entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (ctl.start) begin
          state_nxt = CLR;
          cnt_nxt   = '0;
        end
      end
      CLR: begin
        state_nxt = LOADW;
        cnt_nxt   = CW'(ROWS - 1);
      end
      LOADW: begin
        if (cnt == '0) begin
          if (nv_q == '0) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = STREAM;
            cnt_nxt   = CW'(nv_q) - CW'(1);
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      STREAM: begin
        if (cnt == '0) begin
          state_nxt = DRAIN;
          cnt_nxt   = CW'(LAT - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (abort_acc) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  always_comb begin
    ctl.busy    = (state != IDLE);
    ctl.done    = 1'b0;
    ctl.wght_rd = 1'b0;
    ctl.ifm_rd  = 1'b0;
    ctl.en_w    = 1'b0;
    ctl.clr_w   = 1'b0;
    ctl.en_i    = 1'b0;
    ctl.clr_i   = 1'b0;
    ctl.en_o    = 1'b0;
    ctl.clr_o   = 1'b0;
    case (state)
      CLR: begin
        ctl.clr_w = 1'b1;
        ctl.clr_i = 1'b1;
        ctl.clr_o = 1'b1;
      end
      LOADW: begin
        ctl.en_w    = 1'b1;
        ctl.wght_rd = 1'b1;
      end
      STREAM: begin
        ctl.en_i   = 1'b1;
        ctl.en_o   = 1'b1;
        ctl.ifm_rd = 1'b1;
      end
      // Border ireg held at zero while partial sums keep moving out.
      DRAIN: begin
        ctl.clr_i = 1'b1;
        ctl.en_o  = 1'b1;
      end
      DONE:    ctl.done = 1'b1;
      default: ;
    endcase
  end

  ctrl_delay #(
    .DEPTH(LAT)
  ) u_vld_dly (
    .clk(clk),
    .clr(rst || abort_acc),
    .d  (state == STREAM),
    .q  (ofm_vld)
  );

  assign ctl.ofm_vld = ofm_vld;
  assign ctl.ofm_idx = idx_q;
endmodule

// File: tb/tb_pe_array_ctrl.sv
// Self-checking bench for pe_array_ctrl with ROWS=COLS=4 (LAT=7) and an 8-bit vector count.
// Per-cycle comparison against a timeline model plus tile-level totals from a vector table.
module tb_pe_array_ctrl;
  localparam int R   = 4;
  localparam int C   = 4;
  localparam int LW  = 8;
  localparam int LAT = R + C - 1;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          wght_rd;
    logic          ifm_rd;
    logic          en_w;
    logic          clr_w;
    logic          en_i;
    logic          clr_i;
    logic          en_o;
    logic          clr_o;
    logic          ofm_vld;
    logic [LW-1:0] ofm_idx;
  } obs_t;

  typedef struct {
    int nv;
    int ab;
    int rk;
    int mk;
    int busy;
    int vld;
    int done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  pe_array_ctrl_if #(.LWIDTH(LW)) bus ();

  pe_array_ctrl #(
    .ROWS  (R),
    .COLS  (C),
    .LWIDTH(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctl(bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.busy    = bus.busy;
    o.done    = bus.done;
    o.wght_rd = bus.wght_rd;
    o.ifm_rd  = bus.ifm_rd;
    o.en_w    = bus.en_w;
    o.clr_w   = bus.clr_w;
    o.en_i    = bus.en_i;
    o.clr_i   = bus.clr_i;
    o.en_o    = bus.en_o;
    o.clr_o   = bus.clr_o;
    o.ofm_vld = bus.ofm_vld;
    o.ofm_idx = bus.ofm_idx;
    return o;
  endfunction

  function automatic int tile_end(input int nv);
    return (nv == 0) ? R + 2 : 2 + R + nv + LAT;
  endfunction

  // Expected outputs k cycles after the accepting edge; cut = cycle in which abort/rst is taken.
  function automatic obs_t model(input int k, input int nv, input int cut);
    obs_t e;
    int   s0;
    int   endk;
    e    = '0;
    s0   = 2 + R;
    endk = tile_end(nv);
    if (k < 1 || k > endk || (cut >= 1 && k > cut)) return e;
    e.busy = 1'b1;
    if (k == 1) begin
      e.clr_w = 1'b1;
      e.clr_i = 1'b1;
      e.clr_o = 1'b1;
    end else if (k <= 1 + R) begin
      e.en_w    = 1'b1;
      e.wght_rd = 1'b1;
    end else if (k == endk) begin
      e.done = 1'b1;
    end else if (k < s0 + nv) begin
      e.en_i   = 1'b1;
      e.en_o   = 1'b1;
      e.ifm_rd = 1'b1;
    end else begin
      e.clr_i = 1'b1;
      e.en_o  = 1'b1;
    end
    e.ofm_vld = (nv >= 1) && (k >= s0 + LAT) && (k <= s0 + nv - 1 + LAT);
    if (k >= s0 + LAT) e.ofm_idx = LW'((k - s0 - LAT < nv) ? k - s0 - LAT : nv);
    return e;
  endfunction

  // ab: cycle to abort in (0 = together with start, -1 = none); rk: reset cycle; mk: start-while-busy cycle.
  task automatic run_tile(input int nv, input int ab, input int rk, input int mk, input bit hold,
                          output int nb, output int nvld, output int ndone);
    int   cut;
    int   endk;
    int   last;
    obs_t got;
    obs_t exp;
    cut   = (ab >= 1) ? ab : ((rk >= 1) ? rk : 0);
    endk  = (cut >= 1) ? cut : tile_end(nv);
    last  = endk + (hold ? 1 : 2);
    nb    = 0;
    nvld  = 0;
    ndone = 0;
    bus.start   = 1'b1;
    bus.num_vec = LW'(nv);
    bus.abort   = (ab == 0);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      got = sample();
      exp = model(k, nv, cut);
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL cycle nv=%0d k=%0d got=%h want=%h", nv, k, got, exp);
      end
      nb    += int'(got.busy);
      nvld  += int'(got.ofm_vld);
      ndone += int'(got.done);
      bus.abort = (k == ab);
      rst       = (rk >= 1) && (k == rk);
      if (k == mk) begin
        bus.start   = 1'b1;
        bus.num_vec = LW'(2);
      end else begin
        bus.start   = hold;
        bus.num_vec = LW'($urandom);
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  vec_t tbl[9];

  initial begin
    int   nb;
    int   nvld;
    int   ndone;
    int   nv;
    int   ab;
    obs_t got;

    tbl[0] = '{5,   -1, -1, -1, 18,  5,   1};  // basic tile
    tbl[1] = '{0,   -1, -1, -1, 6,   0,   1};  // empty tile
    tbl[2] = '{3,   -1, -1, 7,  16,  3,   1};  // start while busy
    tbl[3] = '{5,   13, -1, -1, 13,  1,   0};  // abort in third DRAIN cycle
    tbl[4] = '{1,   -1, -1, -1, 14,  1,   1};  // normal tile after abort
    tbl[5] = '{5,   -1, 7,  -1, 7,   0,   0};  // reset in second STREAM cycle
    tbl[6] = '{2,   0,  -1, -1, 15,  2,   1};  // abort with start in IDLE
    tbl[7] = '{255, -1, -1, -1, 268, 255, 1};  // maximum count
    tbl[8] = '{4,   1,  -1, -1, 1,   0,   0};  // abort in CLR

    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.num_vec = '0;
    rst         = 1'b1;
    repeat (2) @(negedge clk);
    got = sample();
    n_cmp++;
    if (got !== obs_t'('0)) begin
      n_fail++;
      $display("FAIL reset got=%h want=%h", got, obs_t'('0));
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_tile(tbl[i].nv, tbl[i].ab, tbl[i].rk, tbl[i].mk, 1'b0, nb, nvld, ndone);
      check_int($sformatf("v%0d_busy", i), nb, tbl[i].busy);
      check_int($sformatf("v%0d_vld", i), nvld, tbl[i].vld);
      check_int($sformatf("v%0d_done", i), ndone, tbl[i].done);
    end

    // Back-to-back: start held through DONE, second tile accepted in the single IDLE cycle.
    run_tile(2, -1, -1, -1, 1'b1, nb, nvld, ndone);
    check_int("b2b_first_busy", nb, 15);
    run_tile(3, -1, -1, -1, 1'b0, nb, nvld, ndone);
    check_int("b2b_second_busy", nb, 16);
    check_int("b2b_second_vld", nvld, 3);

    for (int i = 0; i < 25; i++) begin
      nv = int'($urandom_range(0, 12));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, tile_end(nv))) : -1;
      run_tile(nv, ab, -1, -1, 1'b0, nb, nvld, ndone);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
